// File: rtl/piece_commit_arbiter.sv
// Arbitrates tetromino lock requests and serialises each granted piece's cells into static-board writes.
// Define PIECE_COMMIT_RR_EN for round-robin grant; otherwise the lowest requesting index wins.
module piece_commit_arbiter #(
    parameter int NUM_PIECES = 7,
    parameter int CELLS      = 4,
    parameter int ROW_W      = 5,
    parameter int COL_W      = 4,
    parameter int COLOR_W    = 3,
    parameter int BOARD_ROWS = 20
) (
    input  logic                                Clk,
    input  logic                                Reset_n,
    input  logic [NUM_PIECES-1:0]               Lock_Req,
    input  logic [NUM_PIECES*CELLS*ROW_W-1:0]   Piece_Row,
    input  logic [NUM_PIECES*CELLS*COL_W-1:0]   Piece_Column,
    input  logic [NUM_PIECES*COLOR_W-1:0]       Piece_Color,
    input  logic [NUM_PIECES-1:0]               Piece_Over,
    input  logic                                New_Game,
    input  logic                                Wr_Ready,
    output logic                                Wr_En,
    output logic [ROW_W-1:0]                    Wr_Row,
    output logic [COL_W-1:0]                    Wr_Column,
    output logic [COLOR_W-1:0]                  Wr_Color,
    output logic [NUM_PIECES-1:0]               Lock_Ack,
    output logic                                Busy,
    output logic [$clog2(NUM_PIECES)-1:0]       Grant_Index,
    output logic                                Game_Over
);

    localparam int IDX_W = $clog2(NUM_PIECES);
    localparam int CNT_W = (CELLS > 1) ? $clog2(CELLS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_e;

    state_e                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [CELLS-1:0][ROW_W-1:0]     row_q, row_d;
    logic [CELLS-1:0][COL_W-1:0]     col_q, col_d;
    logic [COLOR_W-1:0]              color_q, color_d;
    logic [IDX_W-1:0]                grant_q, grant_d;
    logic                            game_over_q, game_over_d;

    logic [NUM_PIECES-1:0][CELLS-1:0][ROW_W-1:0] req_rows;
    logic [NUM_PIECES-1:0][CELLS-1:0][COL_W-1:0] req_cols;
    logic [NUM_PIECES-1:0][COLOR_W-1:0]          req_colors;

    logic                            grant_found;
    logic [IDX_W-1:0]                grant_sel;
    logic                            cell_valid;

    // Flattened buses reinterpreted piece-major, then cell.
    assign req_rows   = Piece_Row;
    assign req_cols   = Piece_Column;
    assign req_colors = Piece_Color;

    assign cell_valid = 32'(row_q[cnt_q]) < BOARD_ROWS;

`ifdef PIECE_COMMIT_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] rr_idx;

    always_comb begin
        grant_found = 1'b0;
        grant_sel   = '0;
        rr_idx      = '0;
        for (int unsigned off = 0; off < NUM_PIECES; off++) begin
            rr_idx = IDX_W'((32'(ptr_q) + off) % NUM_PIECES);
            if (!grant_found && Lock_Req[rr_idx]) begin
                grant_found = 1'b1;
                grant_sel   = rr_idx;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        grant_found = 1'b0;
        grant_sel   = '0;
        for (int unsigned i = 0; i < NUM_PIECES; i++) begin
            if (!grant_found && Lock_Req[IDX_W'(i)]) begin
                grant_found = 1'b1;
                grant_sel   = IDX_W'(i);
            end
        end
    end
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            color_q     <= '0;
            grant_q     <= '0;
            game_over_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            color_q     <= color_d;
            grant_q     <= grant_d;
            game_over_q <= game_over_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        color_d = color_q;
        grant_d = grant_q;
`ifdef PIECE_COMMIT_RR_EN
        ptr_d   = ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!game_over_q && grant_found) begin
                    state_d = WRITE;
                    cnt_d   = '0;
                    row_d   = req_rows[grant_sel];
                    col_d   = req_cols[grant_sel];
                    color_d = req_colors[grant_sel];
                    grant_d = grant_sel;
`ifdef PIECE_COMMIT_RR_EN
                    ptr_d   = (grant_sel == IDX_W'(NUM_PIECES - 1)) ? '0 : grant_sel + 1'b1;
`endif
                end
            end
            WRITE: begin
                // Off-board cells consume one cycle without waiting for Wr_Ready.
                if (!cell_valid || Wr_Ready) begin
                    if (cnt_q == CNT_W'(CELLS - 1)) begin
                        state_d = ACK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Set beats clear when top-out and a new game coincide.
        if (|Piece_Over) begin
            game_over_d = 1'b1;
        end else if (New_Game) begin
            game_over_d = 1'b0;
        end else begin
            game_over_d = game_over_q;
        end
    end

    always_comb begin
        Wr_En     = 1'b0;
        Wr_Row    = '0;
        Wr_Column = '0;
        Wr_Color  = '0;
        Lock_Ack  = '0;
        Busy      = (state_q != IDLE);
        if (state_q == WRITE && cell_valid) begin
            Wr_En     = 1'b1;
            Wr_Row    = row_q[cnt_q];
            Wr_Column = col_q[cnt_q];
            Wr_Color  = color_q;
        end
        if (state_q == ACK) begin
            Lock_Ack[grant_q] = 1'b1;
        end
    end

    assign Grant_Index = grant_q;
    assign Game_Over   = game_over_q;

endmodule

// File: tb/tb_piece_commit_arbiter.sv
// Bench for piece_commit_arbiter: queue-based reference model checked every cycle, plus directed scenarios.
// Honours PIECE_COMMIT_RR_EN the same way as the design.
module tb_piece_commit_arbiter;
    localparam int N  = 7;
    localparam int C  = 4;
    localparam int RW = 5;
    localparam int CW = 4;
    localparam int KW = 3;
    localparam int BR = 20;
`ifdef PIECE_COMMIT_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic               Clk = 1'b0;
    logic               Reset_n = 1'b0;
    logic [N-1:0]       Lock_Req = '0;
    logic [N*C*RW-1:0]  Piece_Row = '0;
    logic [N*C*CW-1:0]  Piece_Column = '0;
    logic [N*KW-1:0]    Piece_Color = '0;
    logic [N-1:0]       Piece_Over = '0;
    logic               New_Game = 1'b0;
    logic               Wr_Ready = 1'b1;
    logic               Wr_En;
    logic [RW-1:0]      Wr_Row;
    logic [CW-1:0]      Wr_Column;
    logic [KW-1:0]      Wr_Color;
    logic [N-1:0]       Lock_Ack;
    logic               Busy;
    logic [2:0]         Grant_Index;
    logic               Game_Over;

    int tests = 0;
    int fails = 0;
    logic [N-1:0] req_v = '0;

    piece_commit_arbiter #(
        .NUM_PIECES(N), .CELLS(C), .ROW_W(RW), .COL_W(CW), .COLOR_W(KW), .BOARD_ROWS(BR)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Lock_Req(Lock_Req), .Piece_Row(Piece_Row),
        .Piece_Column(Piece_Column), .Piece_Color(Piece_Color), .Piece_Over(Piece_Over),
        .New_Game(New_Game), .Wr_Ready(Wr_Ready), .Wr_En(Wr_En), .Wr_Row(Wr_Row),
        .Wr_Column(Wr_Column), .Wr_Color(Wr_Color), .Lock_Ack(Lock_Ack), .Busy(Busy),
        .Grant_Index(Grant_Index), .Game_Over(Game_Over)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference model: pending cells of the current commit, in order, plus an ack flag.
    typedef struct packed {
        logic [RW-1:0] r;
        logic [CW-1:0] c;
    } cell_t;

    cell_t         mq[$];
    logic [KW-1:0] m_color = '0;
    int            m_grant = 0;
    int            m_ptr = 0;
    bit            m_ack = 1'b0;
    bit            m_go = 1'b0;
    bit            m_en;
    int            m_w;

    function automatic int pick(input logic [N-1:0] r);
        int w;
        int start;
        w = -1;
        start = RR ? m_ptr : 0;
        for (int o = 0; o < N; o++) begin
            if (w < 0 && r[(start + o) % N]) w = (start + o) % N;
        end
        return w;
    endfunction

    always @(negedge Clk) begin
        if (!Reset_n) begin
            check("rst_wr_en", 32'(Wr_En), 32'd0);
            check("rst_wr_row", 32'(Wr_Row), 32'd0);
            check("rst_lock_ack", 32'(Lock_Ack), 32'd0);
            check("rst_busy", 32'(Busy), 32'd0);
            check("rst_grant", 32'(Grant_Index), 32'd0);
            check("rst_game_over", 32'(Game_Over), 32'd0);
            mq.delete();
            m_color = '0;
            m_grant = 0;
            m_ptr = 0;
            m_ack = 1'b0;
            m_go = 1'b0;
        end else begin
            m_en = (mq.size() > 0) && (int'(mq[0].r) < BR);
            check("wr_en", 32'(Wr_En), 32'(m_en));
            check("wr_row", 32'(Wr_Row), m_en ? 32'(mq[0].r) : 32'd0);
            check("wr_col", 32'(Wr_Column), m_en ? 32'(mq[0].c) : 32'd0);
            check("wr_color", 32'(Wr_Color), m_en ? 32'(m_color) : 32'd0);
            check("lock_ack", 32'(Lock_Ack), m_ack ? (32'd1 << m_grant) : 32'd0);
            check("busy", 32'(Busy), 32'((mq.size() > 0) || m_ack));
            check("grant_index", 32'(Grant_Index), 32'(m_grant));
            check("game_over", 32'(Game_Over), 32'(m_go));

            if (m_ack) begin
                m_ack = 1'b0;
            end else if (mq.size() > 0) begin
                if (int'(mq[0].r) >= BR || Wr_Ready) begin
                    void'(mq.pop_front());
                    if (mq.size() == 0) m_ack = 1'b1;
                end
            end else if (!m_go && Lock_Req != '0) begin
                m_w = pick(Lock_Req);
                m_grant = m_w;
                m_ptr = (m_w + 1) % N;
                m_color = KW'(Piece_Color >> (m_w * KW));
                for (int c = 0; c < C; c++) begin
                    mq.push_back('{r: RW'(Piece_Row >> ((m_w * C + c) * RW)),
                                   c: CW'(Piece_Column >> ((m_w * C + c) * CW))});
                end
            end
            if (Piece_Over != '0) m_go = 1'b1;
            else if (New_Game) m_go = 1'b0;
        end
    end

    task automatic set_piece(input int p, input int r0, input int r1, input int r2, input int r3,
                             input int col, input int color);
        int rs[4];
        rs = '{r0, r1, r2, r3};
        for (int c = 0; c < C; c++) begin
            Piece_Row[(p * C + c) * RW +: RW]    = RW'(rs[c]);
            Piece_Column[(p * C + c) * CW +: CW] = CW'(col);
        end
        Piece_Color[p * KW +: KW] = KW'(color);
    endtask

    task automatic scramble();
        for (int p = 0; p < N; p++) begin
            set_piece(p, $urandom_range(0, 23), $urandom_range(0, 23), $urandom_range(0, 23),
                      $urandom_range(0, 31), $urandom_range(0, 15), $urandom_range(0, 7));
        end
    endtask

    // Requests piece p (data already set) and measures writes, row sum and ack latency.
    task automatic run_commit(input string tag, input int p, input int stall_at, input int stall_len,
                              input int exp_w, input int exp_sum, input int exp_lat);
        int writes, sum, stalled, lat;
        writes = 0; sum = 0; stalled = 0; lat = 0;
        req_v = '0;
        req_v[p] = 1'b1;
        Lock_Req = req_v;
        for (int cyc = 1; cyc <= 40 && lat == 0; cyc++) begin
            tick();
            if (cyc == 1) scramble();
            if (Lock_Ack != '0) begin
                lat = cyc;
                check({tag, "_ack_vec"}, 32'(Lock_Ack), 32'd1 << p);
                req_v = '0;
                Lock_Req = req_v;
            end else if (Wr_En) begin
                if (writes == stall_at && stalled < stall_len) begin
                    Wr_Ready = 1'b0;
                    stalled++;
                end else begin
                    Wr_Ready = 1'b1;
                    writes++;
                    sum += int'(Wr_Row);
                end
            end else begin
                Wr_Ready = 1'b1;
            end
        end
        Wr_Ready = 1'b1;
        req_v = '0;
        Lock_Req = req_v;
        check({tag, "_writes"}, 32'(writes), 32'(exp_w));
        check({tag, "_row_sum"}, 32'(sum), 32'(exp_sum));
        check({tag, "_ack_latency"}, 32'(lat), 32'(exp_lat));
        tick();
    endtask

    task automatic grant_seq(input string tag, input logic [N-1:0] reqs, input bit drop, input int n,
                             input int e0, input int e1, input int e2);
        int gq[$];
        bit prev_busy;
        prev_busy = 1'b0;
        req_v = reqs;
        Lock_Req = req_v;
        for (int cyc = 0; cyc < 80 && gq.size() < n; cyc++) begin
            tick();
            if (Busy && !prev_busy) gq.push_back(int'(Grant_Index));
            prev_busy = Busy;
            if (drop) begin
                req_v = req_v & ~Lock_Ack;
                Lock_Req = req_v;
            end
        end
        req_v = '0;
        Lock_Req = req_v;
        for (int cyc = 0; cyc < 20 && Busy; cyc++) tick();
        tick();
        check({tag, "_count"}, 32'(gq.size()), 32'(n));
        while (gq.size() < 3) gq.push_back(-1);
        check({tag, "_g0"}, 32'(gq[0]), 32'(e0));
        check({tag, "_g1"}, 32'(gq[1]), 32'(e1));
        if (n > 2) check({tag, "_g2"}, 32'(gq[2]), 32'(e2));
    endtask

    initial begin
        int  got;
        int  acks;
        bit  busy_seen;

        tick();
        tick();
        Reset_n = 1'b1;
        tick();

        set_piece(2, 3, 4, 5, 6, 2, 3);
        run_commit("basic", 2, -1, 0, 4, 18, 5);
        set_piece(0, 1, 2, 3, 4, 5, 1);
        run_commit("stall", 0, 1, 3, 4, 10, 8);
        set_piece(4, 18, 19, 20, 31, 7, 6);
        run_commit("partial_skip", 4, -1, 0, 2, 37, 5);
        set_piece(6, 20, 21, 25, 31, 1, 2);
        run_commit("all_skip", 6, -1, 0, 0, 0, 5);

        scramble();
        grant_seq("order_drop", 7'b0000011, 1'b1, 2, 0, 1, 0);
        grant_seq("order_held", 7'b0000011, 1'b0, 3, 0, RR ? 1 : 0, 0);

        set_piece(1, 0, 1, 2, 3, 1, 5);
        req_v = 7'b0000010;
        Lock_Req = req_v;
        tick();
        tick();
        Piece_Over = 7'b0100000;
        tick();
        Piece_Over = '0;
        got = 0;
        for (int cyc = 0; cyc < 20 && got == 0; cyc++) begin
            if (Lock_Ack[1]) got = 1;
            else tick();
        end
        check("go_commit_done", 32'(got), 32'd1);
        req_v = '0;
        Lock_Req = req_v;
        tick();
        check("go_set", 32'(Game_Over), 32'd1);
        req_v = 7'b0001000;
        Lock_Req = req_v;
        busy_seen = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            tick();
            busy_seen |= Busy;
        end
        check("go_ignores_req", 32'(busy_seen), 32'd0);
        req_v = '0;
        Lock_Req = req_v;
        New_Game = 1'b1;
        tick();
        New_Game = 1'b0;
        check("go_clear", 32'(Game_Over), 32'd0);
        New_Game = 1'b1;
        Piece_Over = 7'b0000001;
        tick();
        New_Game = 1'b0;
        Piece_Over = '0;
        check("go_set_wins", 32'(Game_Over), 32'd1);
        New_Game = 1'b1;
        tick();
        New_Game = 1'b0;
        check("go_clear_again", 32'(Game_Over), 32'd0);

        set_piece(5, 7, 8, 9, 10, 3, 2);
        req_v = 7'b0100000;
        Lock_Req = req_v;
        got = 0;
        for (int cyc = 0; cyc < 20 && got == 0; cyc++) begin
            tick();
            if (Wr_En && Wr_Row == 5'd9) got = 1;
        end
        check("rst_reach_cell2", 32'(got), 32'd1);
        req_v = '0;
        Lock_Req = req_v;
        #2;
        Reset_n = 1'b0;
        #1;
        check("arst_wr_en", 32'(Wr_En), 32'd0);
        check("arst_wr_row", 32'(Wr_Row), 32'd0);
        check("arst_wr_col", 32'(Wr_Column), 32'd0);
        check("arst_wr_color", 32'(Wr_Color), 32'd0);
        check("arst_busy", 32'(Busy), 32'd0);
        check("arst_grant", 32'(Grant_Index), 32'd0);
        tick();
        tick();
        Reset_n = 1'b1;
        acks = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            tick();
            if (Lock_Ack != '0) acks++;
        end
        check("rst_no_ack", 32'(acks), 32'd0);

        scramble();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (req_v[i] && Lock_Ack[i]) req_v[i] = 1'b0;
                else if (!req_v[i] && $urandom_range(0, 5) == 0) req_v[i] = 1'b1;
            end
            Lock_Req = req_v;
            scramble();
            Wr_Ready = ($urandom_range(0, 3) != 0);
            Piece_Over = ($urandom_range(0, 79) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
            New_Game = ($urandom_range(0, 9) == 0);
        end
        req_v = '0;
        Lock_Req = req_v;
        Piece_Over = '0;
        New_Game = 1'b0;
        Wr_Ready = 1'b1;
        for (int cyc = 0; cyc < 20 && Busy; cyc++) tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
